// File: rtl/qmul_seq_pkg.sv
// Shared fixed-point constants for the sequential Q-format arithmetic blocks.
// Operands are sign-magnitude: the sign bit is the top bit and the rest is magnitude.
package qmul_seq_pkg;

  localparam int QMUL_Q_DEF        = 15;
  localparam int QMUL_N_DEF        = 32;
  localparam int QMUL_SIGN_BIT_DEF = QMUL_N_DEF - 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } qmul_state_e;

endpackage

// File: rtl/qmul_seq.sv
// Sequential sign-magnitude Q-format multiplier: shift-and-add, one multiplier bit per cycle.
// The result register and the overflow flag change only on the completion edge.
module qmul_seq
  import qmul_seq_pkg::*;
#(
  parameter int Q = QMUL_Q_DEF,
  parameter int N = QMUL_N_DEF
) (
  input  logic         i_clk,
  input  logic         rst,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  input  logic         i_start,
  output logic [N-1:0] o_result_out,
  output logic         o_complete,
  output logic         o_overflow
);

  localparam int MW = N - 1;
  localparam int PW = 2 * N - 2;
  localparam int CW = $clog2(N);

  qmul_state_e    state_q, state_d;
  logic [PW-1:0]  mcand_q, mcand_d;
  logic [MW-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic           sign_q, sign_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   result_q, result_d;
  logic           ovf_q, ovf_d;
  logic [PW-1:0]  acc_sum;

  function automatic logic prod_ovf(input logic [PW-1:0] prod);
    return |prod[PW-1:MW+Q];
  endfunction

  // Truncate toward zero, saturate on overflow, and never emit a negative zero.
  function automatic logic [N-1:0] pack_result(input logic sgn, input logic [PW-1:0] prod);
    logic [MW-1:0] mag;
    mag = prod_ovf(prod) ? '1 : prod[MW-1+Q:Q];
    return {sgn & (|mag), mag};
  endfunction

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          mcand_d  = PW'(i_multiplicand[MW-1:0]);
          mplier_d = i_multiplier[MW-1:0];
          sign_d   = i_multiplicand[N-1] ^ i_multiplier[N-1];
          acc_d    = '0;
          cnt_d    = CW'(N - 2);
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // Last multiplier bit: publish the finished product in the same edge.
          result_d = pack_result(sign_q, acc_sum);
          ovf_d    = prod_ovf(acc_sum);
          cnt_d    = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_result_out = result_q;
  assign o_overflow   = ovf_q;
  assign o_complete   = (state_q == S_IDLE);

endmodule

// File: tb/tb_qmul_seq.sv
// Bench for qmul_seq: directed corner cases plus random operands against an arithmetic model.
module tb_qmul_seq;

  localparam int Q = 15;
  localparam int N = 32;

  logic         i_clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [N-1:0] i_multiplicand;
  logic [N-1:0] i_multiplier;
  logic [N-1:0] o_result_out;
  logic         o_complete;
  logic         o_overflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] exp_res;
  logic         exp_ovf;

  always #5 i_clk = ~i_clk;

  qmul_seq #(.Q(Q), .N(N)) dut (
    .i_clk          (i_clk),
    .rst            (rst),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .i_start        (i_start),
    .o_result_out   (o_result_out),
    .o_complete     (o_complete),
    .o_overflow     (o_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {overflow, result}: exact integer product of the magnitudes, then Q-format rules.
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    longint unsigned maxmag, ma, mb, p, mag;
    logic ov, sgn;
    maxmag = (64'd1 << (N - 1)) - 64'd1;
    ma     = 64'(a) & maxmag;
    mb     = 64'(b) & maxmag;
    p      = ma * mb;
    mag    = p >> Q;
    ov     = (mag > maxmag);
    if (ov) mag = maxmag;
    sgn    = (a[N-1] ^ b[N-1]) && (mag != 0);
    return {ov, sgn, mag[N-2:0]};
  endfunction

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input int inj_at, input int abort_at);
    logic [N:0] m;
    int busy;
    bit aborted;
    m       = model(a, b);
    busy    = 0;
    aborted = 0;
    @(negedge i_clk);
    i_multiplicand = a;
    i_multiplier   = b;
    i_start        = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    while (!o_complete && busy < 40) begin
      busy++;
      chk("hold_res", 64'(o_result_out), 64'(exp_res));
      chk("hold_ovf", 64'(o_overflow), 64'(exp_ovf));
      i_multiplicand = $urandom;
      i_multiplier   = $urandom;
      i_start        = (busy == inj_at);
      if (busy == abort_at) begin
        rst = 1'b1;
        @(negedge i_clk);
        rst     = 1'b0;
        i_start = 1'b0;
        chk("abort_complete", 64'(o_complete), 64'd1);
        chk("abort_res", 64'(o_result_out), 64'd0);
        chk("abort_ovf", 64'(o_overflow), 64'd0);
        exp_res = '0;
        exp_ovf = 1'b0;
        aborted = 1;
        break;
      end
      @(negedge i_clk);
    end
    i_start = 1'b0;
    if (!aborted) begin
      exp_res = m[N-1:0];
      exp_ovf = m[N];
      chk("busy_len", 64'(busy), 64'd31);
      chk("result", 64'(o_result_out), 64'(exp_res));
      chk("overflow", 64'(o_overflow), 64'(exp_ovf));
    end
  endtask

  initial begin
    logic [N-1:0] a, b;
    logic [N:0]   m;
    int busy;

    rst            = 1'b1;
    i_start        = 1'b1;
    i_multiplicand = 32'h0000C000;
    i_multiplier   = 32'h00010000;
    exp_res        = '0;
    exp_ovf        = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("reset_complete", 64'(o_complete), 64'd1);
    chk("reset_res", 64'(o_result_out), 64'd0);
    chk("reset_ovf", 64'(o_overflow), 64'd0);
    rst     = 1'b0;
    i_start = 1'b0;
    @(negedge i_clk);
    chk("idle_complete", 64'(o_complete), 64'd1);

    run_op(32'h0000C000, 32'h00010000, -1, -1);
    chk("pos_1p5x2", 64'(o_result_out), 64'h00018000);
    run_op(32'h8000C000, 32'h00010000, -1, -1);
    chk("neg_times_pos", 64'(o_result_out), 64'h80018000);
    run_op(32'h8000C000, 32'h80010000, -1, -1);
    chk("neg_times_neg", 64'(o_result_out), 64'h00018000);
    run_op(32'h00800000, 32'h00800000, -1, -1);
    chk("ovf_flag", 64'(o_overflow), 64'd1);
    chk("ovf_sat", 64'(o_result_out), 64'h7FFFFFFF);
    run_op(32'h80000001, 32'h00000001, -1, -1);
    chk("neg_zero", 64'(o_result_out), 64'h00000000);
    chk("neg_zero_ovf", 64'(o_overflow), 64'd0);

    run_op(32'h00123456, 32'h8000ABCD, 10, -1);
    run_op(32'h0003C000, 32'h00028000, -1, 15);
    run_op(32'h0003C000, 32'h00028000, -1, -1);

    // Start held high across completion launches a second operation right away.
    a = 32'h80024000;
    b = 32'h00030000;
    m = model(a, b);
    @(negedge i_clk);
    i_multiplicand = a;
    i_multiplier   = b;
    i_start        = 1'b1;
    @(negedge i_clk);
    busy = 0;
    while (!o_complete && busy < 40) begin
      busy++;
      @(negedge i_clk);
    end
    chk("held_len", 64'(busy), 64'd31);
    chk("held_res", 64'(o_result_out), 64'(m[N-1:0]));
    @(negedge i_clk);
    chk("held_restart", 64'(o_complete), 64'd0);
    i_start = 1'b0;
    busy = 0;
    while (!o_complete && busy < 40) begin
      busy++;
      @(negedge i_clk);
    end
    chk("held_len2", 64'(busy), 64'd31);
    chk("held_res2", 64'(o_result_out), 64'(m[N-1:0]));
    exp_res = m[N-1:0];
    exp_ovf = m[N];

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      a[N-2:0] = a[N-2:0] >> $urandom_range(0, 24);
      b[N-2:0] = b[N-2:0] >> $urandom_range(0, 24);
      run_op(a, b, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
